// File: rtl/fp_cls_stage.sv
// -----------------------------------------------------------------------------
// fp_cls_stage
//
// Two-stage pipeline placed in front of a floating-point compare unit.
// Stage S1 captures the raw operands and the sideband fields. Stage S2
// captures, for each operand, a one-hot class vector and a 65-bit extended
// word {sign, ordered magnitude}. Because every value is extended to the same
// layout, an unsigned compare of bits [63:0] orders magnitudes for both
// formats. Both stages use a valid/ready handshake, and when the output is
// not stalled the stage accepts one operation per cycle.
//
// Optional feature (compile-time macro FP_CLS_NANBOX_EN):
//   When the macro is defined, a single-format operand whose upper word
//   [63:32] is not all ones is not a legal NaN-boxed value. Such an operand
//   is treated as the canonical quiet NaN. When the macro is not defined,
//   the upper word is ignored for single format.
//
// Ports
//   clock                   rising-edge clock for all state
//   reset                   synchronous, active-high; clears valid state
//   flush                   discards all in-flight operations
//   in_valid / in_ready     input handshake
//   in_data1 / in_data2     raw 64-bit operand registers
//   in_fmt                  0 = single, 1 = double
//   in_rm                   compare opcode (2 feq, 1 flt, 0 fle), passed through
//   in_tag                  opaque tag, passed through
//   out_valid / out_ready   output handshake
//   out_data1 / out_data2   {sign, ordered magnitude}; zero when out_valid is 0
//   out_class1 / out_class2 one-hot class; zero when out_valid is 0
//                           bit0 -inf, 1 -normal, 2 -subnormal, 3 -zero,
//                           4 +zero, 5 +subnormal, 6 +normal, 7 +inf,
//                           8 sNaN, 9 qNaN
//   out_rm / out_tag        delayed copies of in_rm / in_tag
// -----------------------------------------------------------------------------
module fp_cls_stage #(
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data1,
    input  logic [63:0]      in_data2,
    input  logic             in_fmt,
    input  logic [2:0]       in_rm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [64:0]      out_data1,
    output logic [64:0]      out_data2,
    output logic [9:0]       out_class1,
    output logic [9:0]       out_class2,
    output logic [2:0]       out_rm,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [9:0] CLS_NEG_INF  = 10'b00_0000_0001;
    localparam logic [9:0] CLS_NEG_NORM = 10'b00_0000_0010;
    localparam logic [9:0] CLS_NEG_SUB  = 10'b00_0000_0100;
    localparam logic [9:0] CLS_NEG_ZERO = 10'b00_0000_1000;
    localparam logic [9:0] CLS_POS_ZERO = 10'b00_0001_0000;
    localparam logic [9:0] CLS_POS_SUB  = 10'b00_0010_0000;
    localparam logic [9:0] CLS_POS_NORM = 10'b00_0100_0000;
    localparam logic [9:0] CLS_POS_INF  = 10'b00_1000_0000;
    localparam logic [9:0] CLS_SNAN     = 10'b01_0000_0000;
    localparam logic [9:0] CLS_QNAN     = 10'b10_0000_0000;

    // Returns 1 when a single-format operand carries an illegal NaN box.
    function automatic logic bad_box(input logic [63:0] raw, input logic fmt);
        logic bad_s;
`ifdef FP_CLS_NANBOX_EN
        bad_s = ~fmt & (raw[63:32] != 32'hFFFF_FFFF);
`else
        bad_s = 1'b0 & fmt & raw[63];
`endif
        return bad_s;
    endfunction

    // Returns the one-hot class of one raw operand.
    function automatic logic [9:0] classify(input logic [63:0] raw, input logic fmt);
        logic       sign_s;
        logic       exp_zero_s;
        logic       exp_ones_s;
        logic       mant_zero_s;
        logic       mant_msb_s;
        logic [9:0] cls_s;
        if (fmt) begin
            sign_s      = raw[63];
            exp_zero_s  = (raw[62:52] == 11'h000);
            exp_ones_s  = (raw[62:52] == 11'h7FF);
            mant_zero_s = (raw[51:0] == 52'h0);
            mant_msb_s  = raw[51];
        end else begin
            sign_s      = raw[31];
            exp_zero_s  = (raw[30:23] == 8'h00);
            exp_ones_s  = (raw[30:23] == 8'hFF);
            mant_zero_s = (raw[22:0] == 23'h0);
            mant_msb_s  = raw[22];
        end
        if (exp_ones_s) begin
            if (mant_zero_s) begin
                cls_s = sign_s ? CLS_NEG_INF : CLS_POS_INF;
            end else if (mant_msb_s) begin
                cls_s = CLS_QNAN;
            end else begin
                cls_s = CLS_SNAN;
            end
        end else if (exp_zero_s) begin
            if (mant_zero_s) begin
                cls_s = sign_s ? CLS_NEG_ZERO : CLS_POS_ZERO;
            end else begin
                cls_s = sign_s ? CLS_NEG_SUB : CLS_POS_SUB;
            end
        end else begin
            cls_s = sign_s ? CLS_NEG_NORM : CLS_POS_NORM;
        end
        if (bad_box(raw, fmt)) begin
            cls_s = CLS_QNAN;
        end else begin
            cls_s = cls_s;
        end
        return cls_s;
    endfunction

    // Returns {sign, magnitude}. The magnitude is zero-padded so both formats
    // share one unsigned ordering.
    function automatic logic [64:0] extend(input logic [63:0] raw, input logic fmt);
        logic [64:0] ext_s;
        if (fmt) begin
            ext_s = {raw[63], 1'b0, raw[62:0]};
        end else begin
            ext_s = {raw[31], 33'h0, raw[30:0]};
        end
        if (bad_box(raw, fmt)) begin
            ext_s = {1'b0, 33'h0, 31'h7FC0_0000};
        end else begin
            ext_s = ext_s;
        end
        return ext_s;
    endfunction

    logic             s1_valid_r;
    logic [63:0]      s1_data1_r;
    logic [63:0]      s1_data2_r;
    logic             s1_fmt_r;
    logic [2:0]       s1_rm_r;
    logic [TAG_W-1:0] s1_tag_r;

    logic             s2_valid_r;
    logic [64:0]      s2_data1_r;
    logic [64:0]      s2_data2_r;
    logic [9:0]       s2_class1_r;
    logic [9:0]       s2_class2_r;
    logic [2:0]       s2_rm_r;
    logic [TAG_W-1:0] s2_tag_r;

    logic             s1_en_s;
    logic             s2_en_s;
    logic [9:0]       cls1_s;
    logic [9:0]       cls2_s;
    logic [64:0]      ext1_s;
    logic [64:0]      ext2_s;

    // Stage-enable chain: a stage advances when it is empty or its consumer advances.
    always_comb begin
        s2_en_s  = ~s2_valid_r | out_ready;
        s1_en_s  = ~s1_valid_r | s2_en_s;
        in_ready = s1_en_s & ~flush & ~reset;
    end

    // Classification and extension of the operands held in S1.
    always_comb begin
        cls1_s = classify(s1_data1_r, s1_fmt_r);
        cls2_s = classify(s1_data2_r, s1_fmt_r);
        ext1_s = extend(s1_data1_r, s1_fmt_r);
        ext2_s = extend(s1_data2_r, s1_fmt_r);
    end

    // S1 register: captures the raw operands on accept. Reset and flush drop the entry.
    always_ff @(posedge clock) begin
        if (reset | flush) begin
            s1_valid_r <= 1'b0;
        end else if (s1_en_s) begin
            s1_valid_r <= in_valid;
            s1_data1_r <= in_data1;
            s1_data2_r <= in_data2;
            s1_fmt_r   <= in_fmt;
            s1_rm_r    <= in_rm;
            s1_tag_r   <= in_tag;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // S2 register: the data and class fields are loaded as zero whenever the
    // stage is empty, so the outputs can come straight from the flops.
    always_ff @(posedge clock) begin
        if (reset | flush) begin
            s2_valid_r  <= 1'b0;
            s2_data1_r  <= 65'h0;
            s2_data2_r  <= 65'h0;
            s2_class1_r <= 10'h0;
            s2_class2_r <= 10'h0;
        end else if (s2_en_s) begin
            s2_valid_r <= s1_valid_r;
            s2_rm_r    <= s1_rm_r;
            s2_tag_r   <= s1_tag_r;
            if (s1_valid_r) begin
                s2_data1_r  <= ext1_s;
                s2_data2_r  <= ext2_s;
                s2_class1_r <= cls1_s;
                s2_class2_r <= cls2_s;
            end else begin
                s2_data1_r  <= 65'h0;
                s2_data2_r  <= 65'h0;
                s2_class1_r <= 10'h0;
                s2_class2_r <= 10'h0;
            end
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    assign out_valid  = s2_valid_r;
    assign out_data1  = s2_data1_r;
    assign out_data2  = s2_data2_r;
    assign out_class1 = s2_class1_r;
    assign out_class2 = s2_class2_r;
    assign out_rm     = s2_rm_r;
    assign out_tag    = s2_tag_r;

endmodule

// File: tb/tb_fp_cls_stage.sv
// -----------------------------------------------------------------------------
// tb_fp_cls_stage
//
// Directed testbench for fp_cls_stage. The expected values are worked out by
// hand. It covers the reset state, the classification of each class, the
// format extension, the optional NaN-box handling, back-pressure, flush, and
// reset in the middle of an operation.
// -----------------------------------------------------------------------------
module tb_fp_cls_stage;

    localparam int TAG_W = 5;

    logic             clock;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data1;
    logic [63:0]      in_data2;
    logic             in_fmt;
    logic [2:0]       in_rm;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [64:0]      out_data1;
    logic [64:0]      out_data2;
    logic [9:0]       out_class1;
    logic [9:0]       out_class2;
    logic [2:0]       out_rm;
    logic [TAG_W-1:0] out_tag;

    int n_checks;
    int n_errors;

    fp_cls_stage #(.TAG_W(TAG_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data1   (in_data1),
        .in_data2   (in_data2),
        .in_fmt     (in_fmt),
        .in_rm      (in_rm),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_class1 (out_class1),
        .out_class2 (out_class2),
        .out_rm     (out_rm),
        .out_tag    (out_tag)
    );

    // Free-running clock with a 10-time-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Sends one operation and checks the two-cycle latency, the result, and the zeroed idle outputs.
    task automatic run_one(input string name, input logic fmt, input logic [63:0] d1,
                           input logic [63:0] d2, input logic [TAG_W-1:0] tag,
                           input logic [2:0] rm, input logic [9:0] c1, input logic [9:0] c2,
                           input logic [64:0] e1, input logic [64:0] e2);
        in_valid = 1'b1;
        in_fmt   = fmt;
        in_data1 = d1;
        in_data2 = d2;
        in_tag   = tag;
        in_rm    = rm;
        step();
        in_valid = 1'b0;
        chk({name, "_lat1"}, out_valid, 1'b0);
        step();
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_class1"}, out_class1, c1);
        chk({name, "_class2"}, out_class2, c2);
        chk({name, "_data1"}, out_data1, e1);
        chk({name, "_data2"}, out_data2, e2);
        chk({name, "_tag"}, out_tag, tag);
        chk({name, "_rm"}, out_rm, rm);
        step();
        chk({name, "_idle_valid"}, out_valid, 1'b0);
        chk({name, "_idle_data"}, out_data1, 65'h0);
        chk({name, "_idle_class"}, out_class2, 10'h0);
    endtask

    int          exp_q[$];
    int          sent;
    int          recv;
    logic [TAG_W-1:0] held_tag;
    logic        held_ok;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data1  = 64'h0;
        in_data2  = 64'h0;
        in_fmt    = 1'b0;
        in_rm     = 3'd0;
        in_tag    = '0;
        out_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_data1", out_data1, 65'h0);
        chk("rst_class1", out_class1, 10'h0);
        reset = 1'b0;
        #1;
        chk("rst_release_in_ready", in_ready, 1'b1);

        // Classification vectors
        run_one("dbl_pm_one", 1'b1, 64'h3FF0_0000_0000_0000, 64'hBFF0_0000_0000_0000, 5'd1, 3'd2,
                10'h040, 10'h002, 65'h0_3FF0_0000_0000_0000, 65'h1_3FF0_0000_0000_0000);
        run_one("sgl_nans", 1'b0, 64'hFFFF_FFFF_7F80_0001, 64'hFFFF_FFFF_7FC0_0000, 5'd2, 3'd1,
                10'h100, 10'h200, 65'h0_0000_0000_7F80_0001, 65'h0_0000_0000_7FC0_0000);
        run_one("dbl_zero_sub", 1'b1, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 5'd3, 3'd0,
                10'h008, 10'h020, 65'h1_0000_0000_0000_0000, 65'h0_0000_0000_0000_0001);
        run_one("sgl_inf_sub", 1'b0, 64'hFFFF_FFFF_FF80_0000, 64'hFFFF_FFFF_8000_0001, 5'd4, 3'd2,
                10'h001, 10'h004, 65'h1_0000_0000_7F80_0000, 65'h1_0000_0000_0000_0001);
        run_one("dbl_inf_zero", 1'b1, 64'h7FF0_0000_0000_0000, 64'h0000_0000_0000_0000, 5'd5, 3'd1,
                10'h080, 10'h010, 65'h0_7FF0_0000_0000_0000, 65'h0_0000_0000_0000_0000);
`ifdef FP_CLS_NANBOX_EN
        run_one("sgl_nanbox", 1'b0, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_3F80_0000, 5'd6, 3'd0,
                10'h200, 10'h040, 65'h0_0000_0000_7FC0_0000, 65'h0_0000_0000_3F80_0000);
`else
        run_one("sgl_nanbox", 1'b0, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_3F80_0000, 5'd6, 3'd0,
                10'h040, 10'h040, 65'h0_0000_0000_3F80_0000, 65'h0_0000_0000_3F80_0000);
`endif

        // Back-to-back operations with out_ready held low for cycles 3 to 5
        sent     = 0;
        recv     = 0;
        held_ok  = 1'b0;
        held_tag = '0;
        in_fmt   = 1'b1;
        in_data1 = 64'h3FF0_0000_0000_0000;
        in_data2 = 64'h4000_0000_0000_0000;
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_valid  = (sent < 4);
            in_tag    = TAG_W'(10 + sent);
            out_ready = !(cyc >= 3 && cyc <= 5);
            #1;
            if (cyc == 3) begin
                chk("b2b_in_ready_stall", in_ready, 1'b0);
            end
            if (out_valid && !out_ready) begin
                if (held_ok) begin
                    chk("b2b_hold_tag", out_tag, held_tag);
                end
                held_tag = out_tag;
                held_ok  = 1'b1;
            end else begin
                held_ok = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("b2b_extra_out", 1'b1, 1'b0);
                end else begin
                    chk("b2b_tag_order", out_tag, TAG_W'(exp_q.pop_front()));
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(10 + sent);
                sent++;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("b2b_sent", sent, 4);
        chk("b2b_recv", recv, 4);

        // Flush with two operations in flight
        in_valid = 1'b1;
        in_tag   = 5'd20;
        step();
        in_tag = 5'd21;
        step();
        in_tag = 5'd22;
        flush  = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 1'b0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_out_class", out_class1, 10'h0);
        run_one("post_flush", 1'b1, 64'hFFF8_0000_0000_0000, 64'h3FF0_0000_0000_0000, 5'd23, 3'd2,
                10'h200, 10'h040, 65'h1_7FF8_0000_0000_0000, 65'h0_3FF0_0000_0000_0000);

        // Reset in the middle of an operation
        in_valid = 1'b1;
        in_tag   = 5'd30;
        step();
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk("midrst_release_ready", in_ready, 1'b1);
        run_one("post_reset", 1'b0, 64'hFFFF_FFFF_C000_0000, 64'hFFFF_FFFF_0000_0000, 5'd31, 3'd1,
                10'h002, 10'h010, 65'h1_0000_0000_4000_0000, 65'h0_0000_0000_0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
